// File: rtl/fir_stim_source.sv
// Burst stimulus generator for a FIR filter: saw/triangle/square/impulse samples, then a zero flush.
// Optional feature macro: SAMPLE_SRC_DITHER_EN (LFSR dither on bit 0 of RUN samples).
module fir_stim_source #(
  parameter int          PHASE_W   = 24,
  parameter int          FLUSH_LEN = 41,
  parameter logic [16:0] IMP_AMP   = 17'h0FFFF
) (
  input  logic               clk_100MHz,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         wave_sel,
  input  logic [15:0]        rate_div,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic [15:0]        burst_len,
  output logic [16:0]        x,
  output logic               valid,
  output logic               busy,
  output logic               done,
  output logic [1:0]         dbg_state_o
);

  localparam int FL_W = $clog2(FLUSH_LEN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         wave_q, wave_d;
  logic [15:0]        rate_q, rate_d;
  logic [PHASE_W-1:0] inc_q, inc_d;
  logic [15:0]        blen_q, blen_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [15:0]        div_q, div_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [FL_W-1:0]    flush_q, flush_d;
  logic               stop_pend_q, stop_pend_d;
  logic [16:0]        x_q, x_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic [16:0]        start_x, step_x;
  logic               tick;

`ifdef SAMPLE_SRC_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;
`endif

  function automatic logic [16:0] wave_fn(input logic [1:0] sel, input logic [16:0] p,
                                          input logic first);
    logic [16:0] dbl;
    dbl = {p[15:0], 1'b0};
    case (sel)
      2'd0:    return p;
      2'd1:    return p[16] ? (17'h0FFFF - dbl) : (dbl - 17'h10000);
      2'd2:    return p[16] ? 17'h10001 : 17'h0FFFF;
      default: return first ? IMP_AMP : 17'd0;
    endcase
  endfunction

  // Sample 0 is produced straight from the live inputs on the accepting edge (phase 0).
  always_comb begin
    start_x = wave_fn(wave_sel, 17'd0, 1'b1);
    step_x  = wave_fn(wave_q, phase_q[PHASE_W-1 -: 17], 1'b0);
`ifdef SAMPLE_SRC_DITHER_EN
    start_x[0] = start_x[0] ^ lfsr_q[0];
    step_x[0]  = step_x[0] ^ lfsr_q[0];
`endif
  end

  assign tick = (div_q == 16'd0);

  always_comb begin
    state_d     = state_q;
    wave_d      = wave_q;
    rate_d      = rate_q;
    inc_d       = inc_q;
    blen_d      = blen_q;
    phase_d     = phase_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    flush_d     = flush_q;
    stop_pend_d = stop_pend_q;
    x_d         = x_q;
    valid_d     = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          wave_d      = wave_sel;
          rate_d      = rate_div;
          inc_d       = phase_inc;
          blen_d      = burst_len;
          phase_d     = phase_inc;
          div_d       = rate_div;
          cnt_d       = 16'd1;
          flush_d     = '0;
          stop_pend_d = 1'b0;
          x_d         = start_x;
          valid_d     = 1'b1;
        end
      end
      RUN: begin
        if (stop) stop_pend_d = 1'b1;
        if (tick) begin
          div_d   = rate_q;
          valid_d = 1'b1;
          if (stop || stop_pend_q || (blen_q != 16'd0 && cnt_q == blen_q)) begin
            state_d = DRAIN;
            x_d     = 17'd0;
            flush_d = FL_W'(1);
          end else begin
            x_d     = step_x;
            phase_d = phase_q + inc_q;
            cnt_d   = cnt_q + 16'd1;
          end
        end else begin
          div_d = div_q - 16'd1;
        end
      end
      DRAIN: begin
        // The edge right after the last flush zero closes the burst.
        if (flush_q == FL_W'(FLUSH_LEN)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (tick) begin
          div_d   = rate_q;
          valid_d = 1'b1;
          x_d     = 17'd0;
          flush_d = flush_q + FL_W'(1);
        end else begin
          div_d = div_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SAMPLE_SRC_DITHER_EN
  always_comb begin
    lfsr_d = lfsr_q;
    if (valid_d) lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end
`endif

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q     <= IDLE;
      wave_q      <= '0;
      rate_q      <= '0;
      inc_q       <= '0;
      blen_q      <= '0;
      phase_q     <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      flush_q     <= '0;
      stop_pend_q <= 1'b0;
      x_q         <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
`ifdef SAMPLE_SRC_DITHER_EN
      lfsr_q      <= 16'hACE1;
`endif
    end else begin
      state_q     <= state_d;
      wave_q      <= wave_d;
      rate_q      <= rate_d;
      inc_q       <= inc_d;
      blen_q      <= blen_d;
      phase_q     <= phase_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      flush_q     <= flush_d;
      stop_pend_q <= stop_pend_d;
      x_q         <= x_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
`ifdef SAMPLE_SRC_DITHER_EN
      lfsr_q      <= lfsr_d;
`endif
    end
  end

  assign x           = x_q;
  assign valid       = valid_q;
  assign done        = done_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fir_stim_source.sv
// Directed bench for fir_stim_source: reset, impulse, sawtooth, square, triangle+stop, mid-burst reset.
module tb_fir_stim_source;

  localparam int FLUSH = 41;

  logic        clk_100MHz = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  wave_sel = '0;
  logic [15:0] rate_div = '0;
  logic [23:0] phase_inc = '0;
  logic [15:0] burst_len = '0;
  logic [16:0] x;
  logic        valid, busy, done;
  logic [1:0]  dbg_state;

  int n_pass = 0;
  int n_total = 0;

  logic [16:0] exp_q[$];
  logic [16:0] got_x[$];
  int          got_t[$];
  int          done_t;
  int          hold_bad;
  int          busy_bad;

  fir_stim_source dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .wave_sel   (wave_sel),
    .rate_div   (rate_div),
    .phase_inc  (phase_inc),
    .burst_len  (burst_len),
    .x          (x),
    .valid      (valid),
    .busy       (busy),
    .done       (done),
    .dbg_state_o(dbg_state)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Config inputs are scrambled right after acceptance to show they were latched.
  task automatic start_burst(input logic [1:0] sel, input logic [15:0] rate,
                             input logic [23:0] inc, input logic [15:0] blen);
    wave_sel  = sel;
    rate_div  = rate;
    phase_inc = inc;
    burst_len = blen;
    start     = 1'b1;
    step();
    start     = 1'b0;
    stop      = 1'b0;
    wave_sel  = 2'($urandom_range(0, 3));
    rate_div  = 16'($urandom_range(0, 9));
    phase_inc = 24'($urandom_range(1, 24'hFFFFFF));
    burst_len = 16'($urandom_range(1, 9));
  endtask

  task automatic collect(input int budget, input int stop_after, input int start_at);
    logic [16:0] prev_x;
    got_x.delete();
    got_t.delete();
    done_t   = -1;
    hold_bad = 0;
    busy_bad = 0;
    prev_x   = x;
    for (int i = 0; i < budget; i++) begin
      if (valid) begin
        got_x.push_back(x);
        got_t.push_back(i);
      end else if (x !== prev_x) hold_bad++;
      prev_x = x;
      if (done) begin
        done_t = i;
        if (busy !== 1'b0 || valid !== 1'b0) busy_bad++;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
      stop  = (stop_after > 0 && valid && got_x.size() == stop_after);
      start = (start_at > 0 && valid && got_x.size() == start_at);
      step();
    end
    stop  = 1'b0;
    start = 1'b0;
  endtask

  task automatic verify(input string name, input int period);
    int bad_gap;
    int last;
    check({name, "_count"}, got_x.size(), exp_q.size());
    for (int k = 0; k < got_x.size() && k < exp_q.size(); k++)
      check($sformatf("%s_x%0d", name, k), got_x[k], exp_q[k]);
    bad_gap = 0;
    for (int k = 1; k < got_t.size(); k++)
      if (got_t[k] - got_t[k-1] != period) bad_gap++;
    check({name, "_gap"}, bad_gap, 0);
    last = (got_t.size() > 0) ? got_t[got_t.size()-1] : -100;
    if (got_t.size() > 0) check({name, "_first_t"}, got_t[0], 0);
    check({name, "_done_t"}, done_t, last + 1);
    check({name, "_hold"}, hold_bad, 0);
    check({name, "_busy"}, busy_bad, 0);
  endtask

  task automatic push_flush();
    for (int k = 0; k < FLUSH; k++) exp_q.push_back(17'd0);
  endtask

  initial begin
    int nv;
    int nd;

    // Reset held 3 cycles with start high: outputs stay quiet throughout and after.
    reset = 1'b1;
    start = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("rst_out%0d", c), {x, valid, busy, done}, 20'd0);
    end
    reset = 1'b0;
    start = 1'b0;
    step();
    check("rst_after", {x, valid, busy, done}, 20'd0);
    check("rst_state", dbg_state, 2'd0);

    // Impulse, rate_div=3, one-sample burst.
    start_burst(2'd3, 16'd3, 24'h000000, 16'd1);
    collect(400, 0, 0);
    exp_q = {17'h0FFFF};
    push_flush();
    verify("imp", 4);
    repeat (3) step();

    // Sawtooth, every cycle; stop raised together with start must be ignored.
    stop = 1'b1;
    start_burst(2'd0, 16'd0, 24'h010000, 16'd4);
    collect(200, 0, 0);
    exp_q = {17'h00000, 17'h00200, 17'h00400, 17'h00600};
    push_flush();
    verify("saw", 1);
    repeat (2) step();

    // Square, quarter-cycle phase step.
    start_burst(2'd2, 16'd1, 24'h400000, 16'd4);
    collect(300, 0, 0);
    exp_q = {17'h0FFFF, 17'h0FFFF, 17'h10001, 17'h10001};
    push_flush();
    verify("sq", 2);
    repeat (2) step();

    // Triangle, continuous, stop after 10 samples, start pulse during DRAIN.
    start_burst(2'd1, 16'd2, 24'h100000, 16'd0);
    collect(600, 10, 15);
    exp_q = {17'h10000, 17'h14000, 17'h18000, 17'h1C000, 17'h00000,
             17'h04000, 17'h08000, 17'h0C000, 17'h0FFFF, 17'h0BFFF};
    push_flush();
    verify("tri", 3);
    nv = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (valid || busy) nv++;
    end
    check("tri_idle_after", nv, 0);

    // Reset after 5 valids in RUN: immediate quiet, no done, no further valids.
    start_burst(2'd0, 16'd1, 24'h010000, 16'd0);
    nv = 1;
    for (int c = 0; c < 100 && nv < 5; c++) begin
      step();
      if (valid) nv++;
    end
    check("abort_valids", nv, 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_out", {x, valid, busy, done}, 20'd0);
    check("abort_state", dbg_state, 2'd0);
    nv = 0;
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (valid) nv++;
      if (done) nd++;
    end
    check("abort_no_valid", nv, 0);
    check("abort_no_done", nd, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
